wb_bridge_32to16: RTL and testbench
===================================

Name: wb_bridge_32to16

Overview:
Wishbone width bridge that lets a 32-bit master (the RISC-V fetch/load-store port) reach the 16-bit slaves of the example SoC, such as the boot ROM and 16-bit peripherals. Each 32-bit request is split into up to two 16-bit cycles:
- low halfword first, at even halfword address;
- then high halfword, at odd halfword address.
Read data is reassembled into a 32-bit word; the master receives a single ack or err.

Parameters:
AW, 8, byte-address width; upstream address is [AW-1:2], downstream address is [AW-1:1].
TIMEOUT, 15, max cycles a downstream half-cycle may wait for m_ack_i before abort; 0 disables the watchdog.

Ports:
clk_i  in  1  system clock; all state changes on rising edge.
reset_i  in  1  synchronous, active-high reset.
s_cyc_i  in  1  upstream bus cycle valid.
s_stb_i  in  1  upstream strobe.
s_we_i  in  1  upstream write enable.
s_sel_i  in  4  upstream byte selects; [1:0] map to the low half, [3:2] to the high half.
s_adr_i  in  AW-2  upstream word address.
s_dat_i  in  32  upstream write data.
s_dat_o  out  32  assembled read data.
s_ack_o  out  1  one-cycle transfer-complete pulse.
s_err_o  out  1  one-cycle timeout/abort pulse.
m_cyc_o  out  1  downstream cycle.
m_stb_o  out  1  downstream strobe.
m_we_o  out  1  downstream write enable.
m_sel_o  out  2  downstream byte selects.
m_adr_o  out  AW-1  downstream halfword address.
m_dat_o  out  16  downstream write data.
m_dat_i  in  16  downstream read data.
m_ack_i  in  1  downstream ack; may be combinational from m_stb_o (zero-wait slaves).

Behaviour:
- Reset: all outputs are 0 and state is IDLE. Reset mid-transfer drops m_cyc_o/m_stb_o at the same edge and produces no s_ack_o or s_err_o.
- All outputs are registered.
- States: IDLE, LO, HI, DONE, ERR.
- IDLE:
  - When s_cyc_i & s_stb_i, capture adr, we, sel and dat.
  - Next state is LO if sel[1:0]≠0, else HI if sel[3:2]≠0, else DONE (sel=0 produces no downstream traffic and read data is 0).
- LO:
  - Drive m_cyc_o=m_stb_o=1, m_adr_o={adr,1'b0}, m_sel_o=sel[1:0], m_dat_o=dat[15:0], m_we_o=we.
  - On m_ack_i, latch m_dat_i into data[15:0] (reads only). Go to HI if sel[3:2]≠0, else DONE.
- HI:
  - Same as LO with m_adr_o={adr,1'b1}, m_sel_o=sel[3:2], m_dat_o=dat[31:16].
  - On m_ack_i, latch into data[31:16] and go to DONE.
- Skipped halves leave their data bits 0 on reads.
- m_stb_o stays continuously high LO→HI; the address changes at the transition edge.
- DONE: s_ack_o=1 for exactly one cycle, m_cyc_o=m_stb_o=0, s_dat_o valid; then IDLE.
- s_dat_o holds its value until the next read completes. Writes do not change s_dat_o.
- Latency: with a zero-wait slave, a request sampled at edge N gives m_stb_o high in cycles N+1 (LO) and N+2 (HI), and s_ack_o in cycle N+3. Each slave wait state adds one cycle.
- Back-to-back: IDLE is re-entered the cycle after DONE. A master holding stb there starts a new transfer (one idle cycle between transfers).
- Watchdog (TIMEOUT>0):
  - A per-half counter clears on entry to LO/HI and counts cycles with m_stb_o high and no ack.
  - If no ack arrives by the TIMEOUT-th cycle, go to ERR. ERR gives s_err_o=1 for one cycle and m_cyc_o=0, then IDLE.
- s_cyc_i low while in LO or HI aborts: next state is IDLE, downstream drops, and there is no ack or err.
- Ack and s_cyc_i drop in the same cycle: the abort wins.
- s_ack_o and s_err_o are never asserted together.

Test Plan:
1. Read word address 0 from the boot ROM image, sel=4'hF, zero-wait slave:
   - m_adr_o is 0 in cycle N+1 and 1 in cycle N+2.
   - s_ack_o pulses in cycle N+3 with s_dat_o=32'h00000113.
   - Word 2 reads 32'h00110113; word 5 reads 32'hFF5FF06F.
2. Write 32'hDEADBEEF with sel=4'b1100, 16-bit RAM model:
   - Exactly one downstream cycle: m_adr_o odd, m_sel_o=2'b11, m_dat_o=16'hDEAD.
   - s_ack_o arrives 2 cycles after capture.
   - sel=4'h0 produces no m_stb_o, with s_ack_o at N+1.
3. Slave inserts 3 wait states per half:
   - m_stb_o is held 4 cycles per half with stable address.
   - s_ack_o in cycle N+9; data assembled correctly.
4. TIMEOUT=4, slave never acks:
   - m_stb_o is high exactly 4 cycles.
   - s_err_o pulses once, s_ack_o stays 0.
   - The next request succeeds normally.
5. Reset asserted during HI, and separately s_cyc_i dropped during LO:
   - m_cyc_o/m_stb_o are 0 the next cycle with no ack or err.
   - After reset, all outputs read 0.
6. Master holds s_stb_i high after ack with a new address:
   - The second transfer starts from IDLE one cycle after DONE.
   - Two distinct acks, with correct data for each address.

Source files
------------

// File: rtl/wb_bridge_32to16.sv
// Wishbone width bridge: each 32-bit master request becomes up to two 16-bit
// downstream cycles (low half, then high half), with abort and a per-half watchdog.
module wb_bridge_32to16 #(
  parameter int AW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          s_cyc_i,
  input  logic          s_stb_i,
  input  logic          s_we_i,
  input  logic [3:0]    s_sel_i,
  input  logic [AW-3:0] s_adr_i,
  input  logic [31:0]   s_dat_i,
  output logic [31:0]   s_dat_o,
  output logic          s_ack_o,
  output logic          s_err_o,
  output logic          m_cyc_o,
  output logic          m_stb_o,
  output logic          m_we_o,
  output logic [1:0]    m_sel_o,
  output logic [AW-2:0] m_adr_o,
  output logic [15:0]   m_dat_o,
  input  logic [15:0]   m_dat_i,
  input  logic          m_ack_i
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {IDLE, LO, HI, DONE, ERR} state_t;

  state_t        state, state_nxt;
  logic [AW-3:0] adr, adr_nxt;
  logic          we, we_nxt;
  logic [3:0]    sel, sel_nxt;
  logic [31:0]   dat, dat_nxt;
  logic [31:0]   rdata, rdata_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic          busy_nxt;
  logic          upper_nxt;
  logic [31:0]   s_dat_nxt;
  logic          s_ack_nxt;
  logic          s_err_nxt;
  logic          m_we_nxt;
  logic [1:0]    m_sel_nxt;
  logic [AW-2:0] m_adr_nxt;
  logic [15:0]   m_dat_nxt;

  // A request with no byte lanes enabled still completes, just without traffic.
  function automatic state_t first_state(input logic [3:0] sel_in);
    if (sel_in[1:0] != 2'b00)      return LO;
    else if (sel_in[3:2] != 2'b00) return HI;
    else                           return DONE;
  endfunction

  always_comb begin
    state_nxt = state;
    adr_nxt   = adr;
    we_nxt    = we;
    sel_nxt   = sel;
    dat_nxt   = dat;
    rdata_nxt = rdata;
    cnt_nxt   = cnt;

    case (state)
      IDLE: begin
        if (s_cyc_i && s_stb_i) begin
          adr_nxt   = s_adr_i;
          we_nxt    = s_we_i;
          sel_nxt   = s_sel_i;
          dat_nxt   = s_dat_i;
          rdata_nxt = '0;
          cnt_nxt   = '0;
          state_nxt = first_state(s_sel_i);
        end
      end
      LO, HI: begin
        // Master abort takes priority over a same-cycle ack or timeout.
        if (!s_cyc_i) begin
          state_nxt = IDLE;
        end else if (m_ack_i) begin
          cnt_nxt = '0;
          if (state == LO) begin
            if (!we) rdata_nxt[15:0] = m_dat_i;
            state_nxt = (sel[3:2] != 2'b00) ? HI : DONE;
          end else begin
            if (!we) rdata_nxt[31:16] = m_dat_i;
            state_nxt = DONE;
          end
        end else if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
          state_nxt = ERR;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Outputs are decoded from the next state so every port is a flop.
    busy_nxt  = (state_nxt == LO) || (state_nxt == HI);
    upper_nxt = (state_nxt == HI);
    m_we_nxt  = busy_nxt && we_nxt;
    m_adr_nxt = busy_nxt ? {adr_nxt, upper_nxt} : '0;
    m_sel_nxt = '0;
    m_dat_nxt = '0;
    if (busy_nxt) begin
      m_sel_nxt = upper_nxt ? sel_nxt[3:2] : sel_nxt[1:0];
      m_dat_nxt = upper_nxt ? dat_nxt[31:16] : dat_nxt[15:0];
    end
    s_ack_nxt = (state_nxt == DONE);
    s_err_nxt = (state_nxt == ERR);
    s_dat_nxt = s_dat_o;
    if ((state_nxt == DONE) && !we_nxt) s_dat_nxt = rdata_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= IDLE;
      cnt     <= '0;
      s_dat_o <= '0;
      s_ack_o <= 1'b0;
      s_err_o <= 1'b0;
      m_cyc_o <= 1'b0;
      m_stb_o <= 1'b0;
      m_we_o  <= 1'b0;
      m_sel_o <= '0;
      m_adr_o <= '0;
      m_dat_o <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      s_dat_o <= s_dat_nxt;
      s_ack_o <= s_ack_nxt;
      s_err_o <= s_err_nxt;
      m_cyc_o <= busy_nxt;
      m_stb_o <= busy_nxt;
      m_we_o  <= m_we_nxt;
      m_sel_o <= m_sel_nxt;
      m_adr_o <= m_adr_nxt;
      m_dat_o <= m_dat_nxt;
    end
  end

  // Request capture and read assembly; always reloaded before use.
  always_ff @(posedge clk_i) begin
    adr   <= adr_nxt;
    we    <= we_nxt;
    sel   <= sel_nxt;
    dat   <= dat_nxt;
    rdata <= rdata_nxt;
  end

endmodule

// File: tb/tb_wb_bridge_32to16.sv
// Bench for wb_bridge_32to16: directed and random requests against a
// transaction-level model of expected per-cycle bus activity.
module tb_wb_bridge_32to16;

  localparam int AW = 8;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        s_cyc_i, s_stb_i, s_we_i;
  logic [3:0]  s_sel_i;
  logic [5:0]  s_adr_i;
  logic [31:0] s_dat_i, s_dat_o;
  logic        s_ack_o, s_err_o;
  logic        m_cyc_o, m_stb_o, m_we_o;
  logic [1:0]  m_sel_o;
  logic [6:0]  m_adr_o;
  logic [15:0] m_dat_o, m_dat_i;
  logic        m_ack_i;

  always #5 clk = ~clk;

  wb_bridge_32to16 #(.AW(AW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i), .s_sel_i(s_sel_i),
    .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_dat_o(s_dat_o),
    .s_ack_o(s_ack_o), .s_err_o(s_err_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i)
  );

  // 16-bit slave memory with programmable wait states or no ack at all.
  logic [15:0] img [128];
  logic [15:0] slv_mem [128];
  logic [15:0] ref_mem [128];
  logic        load_mem;
  int          slv_waits;
  bit          slv_noack;
  int          slv_wcnt;
  int          slv_acks;
  logic [6:0]  lw_adr;
  logic [1:0]  lw_sel;
  logic [15:0] lw_dat;

  assign m_ack_i = m_cyc_o && m_stb_o && !slv_noack && (slv_wcnt == slv_waits);
  assign m_dat_i = slv_mem[m_adr_o];

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 128; i++) slv_mem[i] <= img[i];
      slv_wcnt <= 0;
      slv_acks <= 0;
      lw_adr   <= '0;
      lw_sel   <= '0;
      lw_dat   <= '0;
    end else begin
      if (m_stb_o && !m_ack_i) slv_wcnt <= slv_wcnt + 1;
      else                     slv_wcnt <= 0;
      if (m_ack_i) begin
        slv_acks <= slv_acks + 1;
        if (m_we_o) begin
          if (m_sel_o[0]) slv_mem[m_adr_o][7:0]  <= m_dat_o[7:0];
          if (m_sel_o[1]) slv_mem[m_adr_o][15:8] <= m_dat_o[15:8];
          lw_adr <= m_adr_o;
          lw_sel <= m_sel_o;
          lw_dat <= m_dat_o;
        end
      end
    end
  end

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [1:0]  sel;
    logic [6:0]  adr;
    logic [15:0] dat;
    logic        ack;
    logic        err;
    logic [31:0] sdat;
  } rec_t;

  rec_t        expq[$];
  rec_t        cmp_r;
  logic [31:0] mdl_sdat;
  logic [31:0] idle_sdat;
  bit          checking;
  int          nvec, nmis;
  int          stb_cycles, ack_seen, err_seen;
  int          last_ack_cyc, last_err_cyc, cap_cyc;
  logic [31:0] last_ack_dat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected outputs each cycle; with nothing queued the bridge must be idle.
  always @(negedge clk) begin
    if (checking) begin
      if (expq.size() > 0) cmp_r = expq.pop_front();
      else begin
        cmp_r      = '0;
        cmp_r.sdat = idle_sdat;
      end
      idle_sdat = cmp_r.sdat;
      chk("m_cyc", 32'(m_cyc_o), 32'(cmp_r.cyc));
      chk("m_stb", 32'(m_stb_o), 32'(cmp_r.stb));
      chk("s_ack", 32'(s_ack_o), 32'(cmp_r.ack));
      chk("s_err", 32'(s_err_o), 32'(cmp_r.err));
      chk("s_dat", s_dat_o, cmp_r.sdat);
      if (cmp_r.stb) begin
        chk("m_adr", 32'(m_adr_o), 32'(cmp_r.adr));
        chk("m_sel", 32'(m_sel_o), 32'(cmp_r.sel));
        chk("m_dat", 32'(m_dat_o), 32'(cmp_r.dat));
        chk("m_we", 32'(m_we_o), 32'(cmp_r.we));
      end
      if (m_stb_o) stb_cycles++;
      if (s_ack_o) begin
        ack_seen++;
        last_ack_dat = s_dat_o;
        last_ack_cyc = edge_cnt + 1;
      end
      if (s_err_o) begin
        err_seen++;
        last_err_cyc = edge_cnt + 1;
      end
    end
  end

  task automatic push_rec(input logic stb, input logic we, input logic [1:0] sel,
                          input logic [6:0] adr, input logic [15:0] dat,
                          input logic ack, input logic err);
    rec_t r;
    r      = '0;
    r.cyc  = stb;
    r.stb  = stb;
    r.we   = we;
    r.sel  = sel;
    r.adr  = adr;
    r.dat  = dat;
    r.ack  = ack;
    r.err  = err;
    r.sdat = mdl_sdat;
    expq.push_back(r);
  endtask

  // Transaction model: active halves in order, (waits+1) strobe cycles each,
  // or TO strobe cycles and an error if the slave never answers.
  task automatic push_xfer(input logic [5:0] a, input logic w, input logic [3:0] s,
                           input logic [31:0] d, input int waits, input bit noack);
    logic [31:0] rd;
    logic [1:0]  hs;
    logic [15:0] hd;
    logic [6:0]  ha;
    rd = '0;
    for (int h = 0; h < 2; h++) begin
      hs = (h == 0) ? s[1:0] : s[3:2];
      hd = (h == 0) ? d[15:0] : d[31:16];
      ha = {a, h[0]};
      if (hs != 2'b00) begin
        if (noack) begin
          repeat (TO) push_rec(1'b1, w, hs, ha, hd, 1'b0, 1'b0);
          push_rec(1'b0, 1'b0, 2'b00, 7'd0, 16'd0, 1'b0, 1'b1);
          return;
        end
        repeat (waits + 1) push_rec(1'b1, w, hs, ha, hd, 1'b0, 1'b0);
        if (w) begin
          if (hs[0]) ref_mem[ha][7:0]  = hd[7:0];
          if (hs[1]) ref_mem[ha][15:8] = hd[15:8];
        end else begin
          rd[h*16 +: 16] = ref_mem[ha];
        end
      end
    end
    if (!w) mdl_sdat = rd;
    push_rec(1'b0, 1'b0, 2'b00, 7'd0, 16'd0, 1'b1, 1'b0);
  endtask

  task automatic start_req(input logic [5:0] a, input logic w, input logic [3:0] s,
                           input logic [31:0] d, input int waits, input bit noack);
    s_cyc_i    = 1'b1;
    s_stb_i    = 1'b1;
    s_we_i     = w;
    s_sel_i    = s;
    s_adr_i    = a;
    s_dat_i    = d;
    slv_waits  = waits;
    slv_noack  = noack;
    stb_cycles = 0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (expq.size() > 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 32'(expq.size()), 32'd0);
    expq.delete();
  endtask

  task automatic do_xfer(input logic [5:0] a, input logic w, input logic [3:0] s,
                         input logic [31:0] d, input int waits, input bit noack,
                         input bit hold);
    start_req(a, w, s, d, waits, noack);
    @(posedge clk); #1;
    cap_cyc = edge_cnt;
    push_xfer(a, w, s, d, waits, noack);
    wait_drain();
    if (!hold) begin
      s_cyc_i = 1'b0;
      s_stb_i = 1'b0;
    end
  endtask

  // Read request dropped by the master after k low-half strobe cycles.
  task automatic do_abort(input logic [5:0] a, input int k, input int waits, input bit noack);
    int a0, e0;
    a0 = ack_seen;
    e0 = err_seen;
    start_req(a, 1'b0, 4'hF, 32'd0, waits, noack);
    @(posedge clk); #1;
    repeat (k) push_rec(1'b1, 1'b0, 2'b11, {a, 1'b0}, 16'd0, 1'b0, 1'b0);
    repeat (k - 1) begin @(posedge clk); #1; end
    s_cyc_i = 1'b0;
    s_stb_i = 1'b0;
    wait_drain();
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_acks", 32'(ack_seen - a0), 32'd0);
    chk("abort_errs", 32'(err_seen - e0), 32'd0);
  endtask

  logic [5:0]  ra;
  logic        rw;
  logic [3:0]  rs;
  logic [31:0] rdv;
  int          rwt, a_mark, e_mark, ack1;
  bit          rna, rhold;

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    nvec = 0; nmis = 0; checking = 0;
    stb_cycles = 0; ack_seen = 0; err_seen = 0;
    last_ack_cyc = 0; last_err_cyc = 0; cap_cyc = 0; last_ack_dat = '0;
    mdl_sdat = '0; idle_sdat = '0;
    slv_waits = 0; slv_noack = 0;
    for (int i = 0; i < 128; i++) img[i] = 16'($urandom);
    img[0]  = 16'h0113; img[1]  = 16'h0000;
    img[4]  = 16'h0113; img[5]  = 16'h0011;
    img[10] = 16'hF06F; img[11] = 16'hFF5F;
    for (int i = 0; i < 128; i++) ref_mem[i] = img[i];
    load_mem = 1'b1;
    reset_i  = 1'b1;
    s_cyc_i = 0; s_stb_i = 0; s_we_i = 0; s_sel_i = '0; s_adr_i = '0; s_dat_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_dat", s_dat_o, 32'd0);
    chk("rst_outs", {26'd0, s_ack_o, s_err_o, m_cyc_o, m_stb_o, m_we_o, 1'b0}, 32'd0);
    chk("rst_m_bus", {m_adr_o, m_sel_o, m_dat_o}, 32'd0);
    load_mem = 1'b0;
    reset_i  = 1'b0;
    checking = 1;

    // Boot ROM reads, zero-wait.
    do_xfer(6'd0, 1'b0, 4'hF, 32'd0, 0, 1'b0, 1'b0);
    chk("rom0_dat", last_ack_dat, 32'h00000113);
    chk("rom0_lat", 32'(last_ack_cyc - cap_cyc), 32'd3);
    chk("rom0_stb", 32'(stb_cycles), 32'd2);

    // High-half-only write, then an empty-select request.
    a_mark = slv_acks;
    do_xfer(6'h11, 1'b1, 4'b1100, 32'hDEADBEEF, 0, 1'b0, 1'b0);
    chk("wr_lat", 32'(last_ack_cyc - cap_cyc), 32'd2);
    chk("wr_cycles", 32'(slv_acks - a_mark), 32'd1);
    chk("wr_adr", 32'(lw_adr), 32'h23);
    chk("wr_sel", 32'(lw_sel), 32'h3);
    chk("wr_dat", 32'(lw_dat), 32'hDEAD);
    do_xfer(6'h07, 1'b0, 4'h0, 32'd0, 0, 1'b0, 1'b0);
    chk("sel0_lat", 32'(last_ack_cyc - cap_cyc), 32'd1);
    chk("sel0_stb", 32'(stb_cycles), 32'd0);
    chk("sel0_dat", last_ack_dat, 32'd0);

    // Three wait states per half.
    do_xfer(6'd2, 1'b0, 4'hF, 32'd0, 3, 1'b0, 1'b0);
    chk("wait_lat", 32'(last_ack_cyc - cap_cyc), 32'd9);
    chk("wait_stb", 32'(stb_cycles), 32'd8);
    chk("wait_dat", last_ack_dat, 32'h00110113);

    // Silent slave trips the watchdog; the following request still works.
    a_mark = ack_seen;
    e_mark = err_seen;
    do_xfer(6'd0, 1'b0, 4'hF, 32'd0, 0, 1'b1, 1'b0);
    chk("to_stb", 32'(stb_cycles), 32'd4);
    chk("to_err_lat", 32'(last_err_cyc - cap_cyc), 32'd5);
    chk("to_errs", 32'(err_seen - e_mark), 32'd1);
    chk("to_acks", 32'(ack_seen - a_mark), 32'd0);
    do_xfer(6'd5, 1'b0, 4'hF, 32'd0, 3, 1'b0, 1'b0);
    chk("after_to_dat", last_ack_dat, 32'hFF5FF06F);

    // Back-to-back with strobe held through the ack.
    a_mark = ack_seen;
    do_xfer(6'd2, 1'b0, 4'hF, 32'd0, 0, 1'b0, 1'b1);
    chk("b2b_dat1", last_ack_dat, 32'h00110113);
    ack1 = last_ack_cyc;
    do_xfer(6'd5, 1'b0, 4'hF, 32'd0, 0, 1'b0, 1'b0);
    chk("b2b_dat2", last_ack_dat, 32'hFF5FF06F);
    chk("b2b_gap", 32'(cap_cyc - ack1), 32'd1);
    chk("b2b_acks", 32'(ack_seen - a_mark), 32'd2);

    // Master aborts: silent slave, and ack coinciding with the drop.
    do_abort(6'd9, 2, 0, 1'b1);
    do_abort(6'd0, 1, 0, 1'b0);

    // Reset during the high half of a read.
    a_mark = ack_seen;
    e_mark = err_seen;
    start_req(6'd2, 1'b0, 4'hF, 32'd0, 2, 1'b0);
    @(posedge clk); #1;
    repeat (3) push_rec(1'b1, 1'b0, 2'b11, 7'd4, 16'd0, 1'b0, 1'b0);
    push_rec(1'b1, 1'b0, 2'b11, 7'd5, 16'd0, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    reset_i = 1'b1;
    s_cyc_i = 1'b0;
    s_stb_i = 1'b0;
    @(posedge clk); #1;
    reset_i   = 1'b0;
    mdl_sdat  = '0;
    idle_sdat = '0;
    chk("mid_rst_s_dat", s_dat_o, 32'd0);
    chk("mid_rst_outs", {26'd0, s_ack_o, s_err_o, m_cyc_o, m_stb_o, m_we_o, 1'b0}, 32'd0);
    chk("mid_rst_m_bus", {m_adr_o, m_sel_o, m_dat_o}, 32'd0);
    wait_drain();
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_rst_acks", 32'(ack_seen - a_mark), 32'd0);
    chk("mid_rst_errs", 32'(err_seen - e_mark), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      ra    = 6'($urandom_range(0, 63));
      rw    = 1'($urandom_range(0, 1));
      rs    = 4'($urandom_range(0, 15));
      rdv   = $urandom;
      rwt   = $urandom_range(0, 3);
      rna   = ($urandom_range(0, 7) == 0);
      rhold = 1'($urandom_range(0, 1));
      do_xfer(ra, rw, rs, rdv, rwt, rna, rhold);
      if (!rhold) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    s_cyc_i = 1'b0;
    s_stb_i = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    checking = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
